// File: rtl/lfsr_arbiter.sv
// Seeds, reseeds and shares one 8-bit LFSR between two round-robin requesters.
// Optional build macro LFSR_LOCKUP_RESEED_EN adds automatic recovery from all-zero lockup.
module lfsr_arbiter #(
    parameter int unsigned WORD_W = 8,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic              seed_wr,
    input  logic [7:0]        seed_data,
    output logic              lfsr_load,
    output logic [7:0]        lfsr_load_data,
    output logic              lfsr_enable,
    input  logic              lfsr_seq,
    output logic [1:0]        gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WORD_W-1:0] rsp_data,
    output logic              busy,
    output logic              reseed_evt
);

    localparam int unsigned CntW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {StInit, StSeed, StIdle, StRun, StHold} state_e;

    state_e          state;
    logic [CntW-1:0] bit_cnt;
    logic            rr_ptr;
    logic            pend;
    logic [7:0]      seed_pend;
    logic            pick;
    logic            lockup;
    logic            seed_auto;

    // Round robin only matters when both ask; a lone requester wins outright.
    always_comb begin
        pick = (req == 2'b11) ? rr_ptr : req[1];
    end

`ifdef LFSR_LOCKUP_RESEED_EN
    logic [3:0] zero_cnt;

    // Eight consecutive zero outputs means every state bit is zero.
    assign lockup = (zero_cnt == 4'd8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt   <= 4'd0;
            seed_auto  <= 1'b0;
            reseed_evt <= 1'b0;
        end else begin
            reseed_evt <= 1'b0;
            if (lfsr_load) begin
                zero_cnt <= 4'd0;
            end else if (lfsr_enable) begin
                if (lfsr_seq) zero_cnt <= 4'd0;
                else if (!lockup) zero_cnt <= zero_cnt + 4'd1;
            end
            if (state == StHold && rsp_ready && lockup) begin
                seed_auto  <= 1'b1;
                reseed_evt <= 1'b1;
            end else if (state == StSeed) begin
                seed_auto <= 1'b0;
            end
        end
    end
`else
    assign lockup     = 1'b0;
    assign seed_auto  = 1'b0;
    assign reseed_evt = 1'b0;
`endif

    always_comb begin
        lfsr_load      = (state == StInit) || (state == StSeed);
        lfsr_enable    = (state == StRun);
        lfsr_load_data = (state == StSeed && !seed_auto) ? seed_pend : SEED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StInit;
            bit_cnt   <= '0;
            rr_ptr    <= 1'b0;
            pend      <= 1'b0;
            seed_pend <= 8'h00;
            gnt       <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b1;
        end else begin
            if (seed_wr) begin
                seed_pend <= seed_data;
                pend      <= 1'b1;
            end
            case (state)
                StInit: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                StSeed: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    // An automatic reseed leaves the user's pending value queued.
                    if (!seed_auto && !seed_wr) pend <= 1'b0;
                end
                StIdle: begin
                    if (pend) begin
                        state <= StSeed;
                        busy  <= 1'b1;
                    end else if (|req) begin
                        state   <= StRun;
                        busy    <= 1'b1;
                        rsp_id  <= pick;
                        gnt     <= pick ? 2'b10 : 2'b01;
                        bit_cnt <= '0;
                    end
                end
                StRun: begin
                    rsp_data <= WORD_W'({rsp_data, lfsr_seq});
                    if (bit_cnt == CntW'(WORD_W - 1)) begin
                        state     <= StHold;
                        rsp_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        gnt       <= 2'b00;
                        rr_ptr    <= ~rsp_id;
                        // Going straight to SEED keeps a queued reseed to one cycle of delay.
                        if (lockup || pend) begin
                            state <= StSeed;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter with a behavioural model of the shared LFSR.
module tb_lfsr_arbiter;

    localparam int unsigned WORD_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req = 2'b00;
    logic              seed_wr = 1'b0;
    logic [7:0]        seed_data = 8'h00;
    logic              lfsr_load;
    logic [7:0]        lfsr_load_data;
    logic              lfsr_enable;
    logic              lfsr_seq;
    logic [1:0]        gnt;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_id;
    logic [WORD_W-1:0] rsp_data;
    logic              busy;
    logic              reseed_evt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] lfsr_state;

    lfsr_arbiter #(.WORD_W(WORD_W), .SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .req(req), .seed_wr(seed_wr), .seed_data(seed_data),
        .lfsr_load(lfsr_load), .lfsr_load_data(lfsr_load_data), .lfsr_enable(lfsr_enable),
        .lfsr_seq(lfsr_seq), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .reseed_evt(reseed_evt)
    );

    always #5 clk = ~clk;

    // Shared LFSR: taps 7,6,3,2,1,0, left shift, serial output is bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_state <= 8'h00;
        else if (lfsr_load) lfsr_state <= lfsr_load_data;
        else if (lfsr_enable) lfsr_state <= {lfsr_state[6:0], ^(lfsr_state & 8'b1100_1111)};
    end
    assign lfsr_seq = lfsr_state[0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 40);
        if (!rsp_valid) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_id: got %b want 0", rsp_id); end
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", rsp_data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
        vectors++; if (reseed_evt !== 1'b0) begin miscompares++; $display("FAIL reset_evt: got %b want 0", reseed_evt); end
        vectors++; if (lfsr_enable !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b want 0", lfsr_enable); end
        vectors++; if (lfsr_load !== 1'b1) begin miscompares++; $display("FAIL reset_load: got %b want 1", lfsr_load); end
        vectors++; if (lfsr_load_data !== 8'hA5) begin miscompares++; $display("FAIL reset_ldata: got %h want a5", lfsr_load_data); end
        rst = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL init_idle_busy: got %b want 0", busy); end
        vectors++; if (lfsr_load !== 1'b0) begin miscompares++; $display("FAIL init_idle_load: got %b want 0", lfsr_load); end
    endtask

    task automatic test_single();
        int n;
        req = 2'b01;
        tick();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b want 01", gnt); end
        vectors++; if (lfsr_enable !== 1'b1) begin miscompares++; $display("FAIL single_en: got %b want 1", lfsr_enable); end
        wait_valid(n);
        vectors++; if (n !== 8) begin miscompares++; $display("FAIL single_latency: got %0d want 8", n); end
        vectors++; if (rsp_data !== 8'hDA) begin miscompares++; $display("FAIL single_data: got %h want da", rsp_data); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL single_id: got %b want 0", rsp_id); end
        vectors++; if (lfsr_enable !== 1'b0) begin miscompares++; $display("FAIL single_hold_en: got %b want 0", lfsr_enable); end
        req = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_hs_valid: got %b want 0", rsp_valid); end
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL single_hs_gnt: got %b want 00", gnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_hs_busy: got %b want 0", busy); end
    endtask

    // Both requesting back to back; pointer starts at 1 after the single-word test.
    task automatic test_back_to_back();
        logic [7:0] words [4];
        logic       ids   [4];
        int n;
        words = '{8'h09, 8'h5C, 8'hF0, 8'h18};
        ids   = '{1'b1, 1'b0, 1'b1, 1'b0};
        req = 2'b11;
        rsp_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            wait_valid(n);
            vectors++; if (n !== ((w == 0) ? 9 : 10)) begin miscompares++; $display("FAIL b2b_period%0d: got %0d want %0d", w, n, (w == 0) ? 9 : 10); end
            vectors++; if (rsp_data !== words[w]) begin miscompares++; $display("FAIL b2b_data%0d: got %h want %h", w, rsp_data, words[w]); end
            vectors++; if (rsp_id !== ids[w]) begin miscompares++; $display("FAIL b2b_id%0d: got %b want %b", w, rsp_id, ids[w]); end
            vectors++; if (gnt !== (ids[w] ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL b2b_gnt%0d: got %b want %b", w, gnt, ids[w] ? 2'b10 : 2'b01); end
            if (w == 3) req = 2'b00;
        end
        tick();
        rsp_ready = 1'b0;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL b2b_end_gnt: got %b want 00", gnt); end
    endtask

    task automatic test_hold_stall();
        int n;
        req = 2'b01;
        wait_valid(n);
        vectors++; if (n !== 9) begin miscompares++; $display("FAIL stall_latency: got %0d want 9", n); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid%0d: got %b want 1", i, rsp_valid); end
            vectors++; if (rsp_data !== 8'hFA) begin miscompares++; $display("FAIL stall_data%0d: got %h want fa", i, rsp_data); end
            vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL stall_gnt%0d: got %b want 01", i, gnt); end
            vectors++; if (lfsr_enable !== 1'b0) begin miscompares++; $display("FAIL stall_en%0d: got %b want 0", i, lfsr_enable); end
        end
        req = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_hs_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reseed_run();
        int n;
        req = 2'b10;
        tick();
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL reseed_gnt: got %b want 10", gnt); end
        tick();
        tick();
        seed_wr = 1'b1;
        seed_data = 8'hA5;
        tick();
        seed_wr = 1'b0;
        wait_valid(n);
        vectors++; if (rsp_data !== 8'h5B) begin miscompares++; $display("FAIL reseed_cur_data: got %h want 5b", rsp_data); end
        vectors++; if (rsp_id !== 1'b1) begin miscompares++; $display("FAIL reseed_cur_id: got %b want 1", rsp_id); end
        req = 2'b01;
        rsp_ready = 1'b1;
        tick();
        vectors++; if (lfsr_load !== 1'b1) begin miscompares++; $display("FAIL reseed_load: got %b want 1", lfsr_load); end
        vectors++; if (lfsr_load_data !== 8'hA5) begin miscompares++; $display("FAIL reseed_ldata: got %h want a5", lfsr_load_data); end
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reseed_gap_gnt: got %b want 00", gnt); end
        tick();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reseed_idle_gnt: got %b want 00", gnt); end
        tick();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL reseed_next_gnt: got %b want 01", gnt); end
        wait_valid(n);
        vectors++; if (rsp_data !== 8'hDA) begin miscompares++; $display("FAIL reseed_next_data: got %h want da", rsp_data); end
        req = 2'b00;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_zero_seed();
        int n;
        seed_wr = 1'b1;
        seed_data = 8'h00;
        tick();
        seed_wr = 1'b0;
        req = 2'b01;
        wait_valid(n);
        vectors++; if (n !== 11) begin miscompares++; $display("FAIL zero_latency: got %0d want 11", n); end
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL zero_data: got %h want 00", rsp_data); end
        rsp_ready = 1'b1;
        tick();
`ifdef LFSR_LOCKUP_RESEED_EN
        vectors++; if (reseed_evt !== 1'b1) begin miscompares++; $display("FAIL zero_evt: got %b want 1", reseed_evt); end
        vectors++; if (lfsr_load_data !== 8'hA5) begin miscompares++; $display("FAIL zero_ldata: got %h want a5", lfsr_load_data); end
        tick();
        vectors++; if (reseed_evt !== 1'b0) begin miscompares++; $display("FAIL zero_evt_pulse: got %b want 0", reseed_evt); end
        wait_valid(n);
        vectors++; if (rsp_data !== 8'hDA) begin miscompares++; $display("FAIL zero_next_data: got %h want da", rsp_data); end
`else
        vectors++; if (reseed_evt !== 1'b0) begin miscompares++; $display("FAIL zero_evt: got %b want 0", reseed_evt); end
        vectors++; if (lfsr_load !== 1'b0) begin miscompares++; $display("FAIL zero_load: got %b want 0", lfsr_load); end
        wait_valid(n);
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL zero_next_data: got %h want 00", rsp_data); end
`endif
        vectors++; if (n !== 9) begin miscompares++; $display("FAIL zero_next_latency: got %0d want 9", n); end
        req = 2'b00;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        req = 2'b11;
        tick();
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL midrst_pre_gnt: got %b want 10", gnt); end
        tick();
        seed_wr = 1'b1;
        seed_data = 8'h3C;
        tick();
        seed_wr = 1'b0;
        rst = 1'b1;
        #1;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL midrst_gnt: got %b want 00", gnt); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL midrst_id: got %b want 0", rsp_id); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy: got %b want 1", busy); end
        vectors++; if (lfsr_enable !== 1'b0) begin miscompares++; $display("FAIL midrst_en: got %b want 0", lfsr_enable); end
        vectors++; if (lfsr_load !== 1'b1) begin miscompares++; $display("FAIL midrst_load: got %b want 1", lfsr_load); end
        vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %h want 00", rsp_data); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_busy: got %b want 0", busy); end
        tick();
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL midrst_gnt_after: got %b want 01", gnt); end
        wait_valid(n);
        vectors++; if (n !== 8) begin miscompares++; $display("FAIL midrst_latency: got %0d want 8", n); end
        vectors++; if (rsp_data !== 8'hDA) begin miscompares++; $display("FAIL midrst_word: got %h want da", rsp_data); end
        req = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_stall();
        test_reseed_run();
        test_zero_seed();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
